// File: rtl/flow_counter_pkg.sv
// ============================================================================
// Module  : flow_counter_pkg
// Purpose : Shared types and constants for the flow counter RMW controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package flow_counter_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Control part of a pipeline op; id/delta widths are added per instance.
    typedef struct packed {
        logic valid;
        logic clear;
        logic is_host;
    } op_ctl_t;

    localparam int HOST_LATENCY = 2;

endpackage

`default_nettype wire

// File: rtl/tdp_bram.sv
// ============================================================================
// Module  : tdp_bram
// Purpose : True dual-port block RAM, read-first on port A, one clock.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tdp_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wea_i,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    input  logic [DATA_WIDTH-1:0] dina_i,
    output logic [DATA_WIDTH-1:0] douta_o,
    input  logic                  web_i,
    input  logic [ADDR_WIDTH-1:0] addrb_i,
    input  logic [DATA_WIDTH-1:0] dinb_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] douta_q;

    // A read colliding with a write to the same address returns the old data.
    always_ff @(posedge clk) begin
        if (wea_i) begin
            mem_q[addra_i] <= dina_i;
        end
        if (web_i) begin
            mem_q[addrb_i] <= dinb_i;
        end
        douta_q <= mem_q[addra_i];
    end

    assign douta_o = douta_q;

endmodule

`default_nettype wire

// File: rtl/flow_counter_ctrl.sv
// ============================================================================
// Module  : flow_counter_ctrl
// Purpose : Per-flow counter RMW controller with host read/clear and zero
//           sweep. Define COUNTER_SAT_EN for saturating increments.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module flow_counter_ctrl
    import flow_counter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DELTA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc_valid,
    output logic                   inc_ready,
    input  logic [ADDR_WIDTH-1:0]  inc_id,
    input  logic [DELTA_WIDTH-1:0] inc_delta,
    input  logic                   host_req_valid,
    output logic                   host_req_ready,
    input  logic [ADDR_WIDTH-1:0]  host_req_id,
    input  logic                   host_req_clear,
    output logic                   host_rsp_valid,
    output logic [DATA_WIDTH-1:0]  host_rsp_data,
    output logic                   init_done
);

    typedef struct packed {
        op_ctl_t                ctl;
        logic [ADDR_WIDTH-1:0]  id;
        logic [DELTA_WIDTH-1:0] delta;
    } op_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
    logic                  sweep_we;

    op_t                   s0_op, s1_q;
    logic                  issue_host, issue_inc;

    logic [DATA_WIDTH-1:0] douta;
    logic [DATA_WIDTH-1:0] s1_old, s1_inc, s1_new;

    logic                  s2_valid_q, s2_host_q;
    logic [ADDR_WIDTH-1:0] s2_id_q;
    logic [DATA_WIDTH-1:0] s2_new_q, s2_old_q;

    logic                  lw_valid_q;
    logic [ADDR_WIDTH-1:0] lw_id_q;
    logic [DATA_WIDTH-1:0] lw_val_q;

    logic                  web;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dinb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + ADDR_WIDTH'(1);
                if (sweep_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        init_done = (state_q == ST_RUN);
        sweep_we  = (state_q == ST_INIT);
    end

    // Host has strict priority; readies never look at inc_valid.
    assign host_req_ready = init_done;
    assign inc_ready      = init_done & ~host_req_valid;
    assign issue_host     = host_req_valid & host_req_ready;
    assign issue_inc      = inc_valid & inc_ready;

    always_comb begin
        s0_op             = '0;
        s0_op.ctl.valid   = issue_host | issue_inc;
        s0_op.ctl.is_host = issue_host;
        s0_op.ctl.clear   = issue_host & host_req_clear;
        s0_op.id          = host_req_valid ? host_req_id : inc_id;
        s0_op.delta       = issue_host ? '0 : inc_delta;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
        end else begin
            s1_q <= s0_op;
        end
    end

    // The in-S2 op is newer than the last-written entry, so it wins.
    always_comb begin
        if (s2_valid_q && (s2_id_q == s1_q.id)) begin
            s1_old = s2_new_q;
        end else if (lw_valid_q && (lw_id_q == s1_q.id)) begin
            s1_old = lw_val_q;
        end else begin
            s1_old = douta;
        end
    end

`ifdef COUNTER_SAT_EN
    logic [DATA_WIDTH:0] s1_sum;
    always_comb begin
        s1_sum = {1'b0, s1_old} + (DATA_WIDTH+1)'(s1_q.delta);
        s1_inc = s1_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : s1_sum[DATA_WIDTH-1:0];
    end
`else
    always_comb begin
        s1_inc = s1_old + DATA_WIDTH'(s1_q.delta);
    end
`endif

    assign s1_new = s1_q.ctl.clear ? '0 : s1_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_host_q  <= 1'b0;
            s2_id_q    <= '0;
            s2_new_q   <= '0;
            s2_old_q   <= '0;
            lw_valid_q <= 1'b0;
            lw_id_q    <= '0;
            lw_val_q   <= '0;
        end else begin
            s2_valid_q <= s1_q.ctl.valid;
            s2_host_q  <= s1_q.ctl.is_host;
            s2_id_q    <= s1_q.id;
            s2_new_q   <= s1_new;
            s2_old_q   <= s1_old;
            lw_valid_q <= s2_valid_q;
            lw_id_q    <= s2_id_q;
            lw_val_q   <= s2_new_q;
        end
    end

    always_comb begin
        web   = sweep_we | s2_valid_q;
        addrb = sweep_we ? sweep_q : s2_id_q;
        dinb  = sweep_we ? '0 : s2_new_q;
    end

    assign host_rsp_valid = s2_valid_q & s2_host_q;
    assign host_rsp_data  = host_rsp_valid ? s2_old_q : '0;

    tdp_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bram (
        .clk     (clk),
        .wea_i   (1'b0),
        .addra_i (s0_op.id),
        .dina_i  ('0),
        .douta_o (douta),
        .web_i   (web),
        .addrb_i (addrb),
        .dinb_i  (dinb)
    );

endmodule

`default_nettype wire
